replay_ctrl_p: RTL and testbench
================================

Name: replay_ctrl_p

Overview:
Parametrised second-generation controller for the data-link-layer replay buffer. It sequences TLP writes segment-by-segment into the FIFO, forwards ACKs to advance the read pointer, and runs NAK/timeout replays once the physical layer is free. New in this generation:
- one segment per clock;
- configurable TLP, index and counter widths;
- an exact replay count;
- a REPLAY_NUM rollover counter that requests link retrain.

Parameters:
SEGS_PER_TLP, 10, segments per TLP written per write burst (>=2)
CNT_W, 12, width of count, num_to_rep and internal count_to
SEL_W, 4, width of seg_sel; must satisfy 2**SEL_W >= SEGS_PER_TLP
REPLAY_LIMIT, 4, replays without an intervening ACK before retrain is requested (>=1)
RN_W, 2, width of replay_num; must satisfy 2**RN_W >= REPLAY_LIMIT

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
we_i  in  1  write request from transaction layer (level, held until serviced)
acknak_i  in  2  01=ACK, 10=NAK, 00/11=none (level, held until serviced)
to_i  in  1  replay timer expired (level)
busy_n  in  1  physical layer free when 1
rdy_i  in  1  FIFO ready
num_to_rep  in  CNT_W  entries to replay, supplied by FIFO
rst_o  out  1  FIFO reset pulse
we_o  out  1  FIFO write strobe
to_o  out  1  timeout forwarded to FIFO
acknak_o  out  2  ACK/NAK forwarded to FIFO
rdy_o  out  1  ready to transaction layer
busy_n_o  out  1  0 = controller busy, upstream must stall
rep_o  out  1  replay read strobe
seg_sel  out  SEL_W  segment mux select
count  out  CNT_W  write segment / replay index
replay_num  out  RN_W  consecutive replays since last ACK
retrain_o  out  1  link retrain request pulse

Behaviour:
- Outputs are decoded from the registered state and registers (Moore). The only exception is rdy_o = rdy_i while in IDLE, and 0 in every other state.
- While reset is high:
  - state=RESET; rst_o=1, busy_n_o=1;
  - every other output and all internal registers are 0.
- RESET: held one cycle after reset falls, with rst_o=1 and busy_n_o=1. Then goes to IDLE.
- IDLE:
  - busy_n_o=1; count cleared to 0.
  - Requests are sampled only in this state, with priority we_i > ACK (01) > NAK (10) or to_i. acknak_i=11 is ignored.
  - A lower-priority request must stay asserted until serviced; it is handled on the first IDLE cycle after the higher one completes.
- WRITE:
  - we_o=1, busy_n_o=1, seg_sel=count[SEL_W-1:0]; count increments each cycle.
  - Exactly SEGS_PER_TLP consecutive we_o cycles, with seg_sel running 0..SEGS_PER_TLP-1.
  - After the cycle with count==SEGS_PER_TLP-1, go to IDLE.
- ACK: one cycle, acknak_o=01, busy_n_o=1. replay_num is cleared to 0. Then IDLE.
- REPLAY_REQ: one cycle, busy_n_o=0.
  - Latches to_lat=to_i and ak_lat=(acknak_i==10)?10:00, and drives them on to_o/acknak_o.
  - If replay_num==REPLAY_LIMIT-1, go to RETRAIN.
  - Otherwise replay_num increments and the FSM goes to WAIT_BUSY.
- RETRAIN: one cycle, retrain_o=1, busy_n_o=0, to_o/acknak_o held. replay_num is cleared to 0. Then WAIT_BUSY; the replay is still performed.
- WAIT_BUSY:
  - busy_n_o=0; to_o/acknak_o held from the latch; count_to is loaded from num_to_rep every cycle.
  - Stays until busy_n=1. Then go to REPLAY_RD if num_to_rep != 0, otherwise to IDLE (nothing to replay).
- REPLAY_RD:
  - rep_o=1, busy_n_o=0, to_o/acknak_o=0; count is the FIFO index.
  - count starts at 0 and increments each cycle, giving exactly count_to rep_o cycles with indices 0..count_to-1.
  - After count==count_to-1, go to IDLE. busy_n falling mid-replay is ignored.
- Every counter increment is modulo its width. count never exceeds count_to-1 in REPLAY_RD, and never exceeds SEGS_PER_TLP-1 in WRITE.
- Reset asserted in any state returns the FSM to RESET on the next edge and aborts any burst or replay. replay_num is cleared.
- Illegal state codes go to RESET.

Test Plan:
- Reset held 3 cycles then released -> during reset rst_o=1, busy_n_o=1, others 0; one further rst_o=1 cycle; IDLE with rdy_o tracking rdy_i.
- we_i=1 for one IDLE cycle (SEGS_PER_TLP=10) -> 10 consecutive cycles of we_o=1 with seg_sel 0..9; back in IDLE the next cycle; count=0.
- we_i=1 and acknak_i=01 together -> full 10-cycle write first; acknak_o=01 for one cycle immediately afterwards; replay_num=0.
- acknak_i=10, num_to_rep=5, busy_n held 0 for 4 cycles then 1 -> acknak_o=10 and busy_n_o=0 throughout wait; exactly 5 rep_o cycles with count 0..4; then IDLE.
- Four to_i replays with no ACK (REPLAY_LIMIT=4) -> replay_num 1,2,3; on the 4th, retrain_o pulses once, replay_num=0, and the replay still completes.
- num_to_rep=0 at busy_n rise -> no rep_o pulse; IDLE next cycle. Separately, reset asserted mid-REPLAY_RD -> rep_o=0 and rst_o=1 on the next edge.

Source files
------------

// File: rtl/replay_ctrl_p.sv
// replay_ctrl_p
// Sequencing controller for the data-link-layer replay buffer.
//   - Writes one TLP as SEGS_PER_TLP consecutive segment strobes.
//   - Forwards an ACK to the FIFO for one cycle.
//   - On a NAK or a timeout, waits for the physical layer to go free and then
//     issues exactly num_to_rep replay read strobes.
//   - Counts consecutive replays. Every REPLAY_LIMIT-th replay without an
//     intervening ACK raises a one-cycle link retrain request.
//
// State table:
//   RESET      | FIFO reset pulse; held one cycle after reset falls
//   IDLE       | sample requests (we_i > ACK > NAK/to_i); rdy_o follows rdy_i
//   WRITE      | one segment strobe per cycle, seg_sel 0..SEGS_PER_TLP-1
//   ACK        | forward ACK for one cycle; clear replay_num
//   REPLAY_REQ | latched NAK/timeout on outputs; bump replay_num or retrain
//   RETRAIN    | one-cycle retrain pulse; clear replay_num; replay still runs
//   WAIT_BUSY  | stall until busy_n; track num_to_rep into count_to
//   REPLAY_RD  | count_to replay strobes with index 0..count_to-1
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   we_i          write request (level)
//   acknak_i      01=ACK, 10=NAK, other codes are ignored (level)
//   to_i          replay timer expired (level)
//   busy_n        physical layer free when high
//   rdy_i         FIFO ready
//   num_to_rep    number of entries to replay
//   rst_o         FIFO reset
//   we_o          FIFO write strobe
//   seg_sel       segment select
//   to_o          forwarded timeout
//   acknak_o      forwarded ACK/NAK
//   rdy_o         ready to the transaction layer
//   busy_n_o      low while the controller is busy
//   rep_o         replay read strobe
//   count         write segment / replay index
//   replay_num    consecutive replays since the last ACK
//   retrain_o     link retrain request
module replay_ctrl_p #(
    parameter int SEGS_PER_TLP = 10,
    parameter int CNT_W        = 12,
    parameter int SEL_W        = 4,
    parameter int REPLAY_LIMIT = 4,
    parameter int RN_W         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [1:0]       acknak_i,
    input  logic             to_i,
    input  logic             busy_n,
    input  logic             rdy_i,
    input  logic [CNT_W-1:0] num_to_rep,
    output logic             rst_o,
    output logic             we_o,
    output logic             to_o,
    output logic [1:0]       acknak_o,
    output logic             rdy_o,
    output logic             busy_n_o,
    output logic             rep_o,
    output logic [SEL_W-1:0] seg_sel,
    output logic [CNT_W-1:0] count,
    output logic [RN_W-1:0]  replay_num,
    output logic             retrain_o
);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_IDLE       = 3'd1,
        S_WRITE      = 3'd2,
        S_ACK        = 3'd3,
        S_REPLAY_REQ = 3'd4,
        S_RETRAIN    = 3'd5,
        S_WAIT_BUSY  = 3'd6,
        S_REPLAY_RD  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] SEG_LAST = CNT_W'(SEGS_PER_TLP - 1);
    localparam logic [RN_W-1:0]  RN_LAST  = RN_W'(REPLAY_LIMIT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_to;
    logic [RN_W-1:0]  replay_num_q;
    logic             to_lat;
    logic [1:0]       ak_lat;

    logic write_done;
    logic replay_done;
    logic req_ack;
    logic req_replay;

    assign write_done  = (count_q == SEG_LAST);
    assign replay_done = (count_q == count_to - CNT_W'(1));
    assign req_ack     = (acknak_i == 2'b01);
    assign req_replay  = (acknak_i == 2'b10) || to_i;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_RESET;
        case (state)
            S_RESET: state_nxt = S_IDLE;
            S_IDLE: begin
                if (we_i)            state_nxt = S_WRITE;
                else if (req_ack)    state_nxt = S_ACK;
                else if (req_replay) state_nxt = S_REPLAY_REQ;
                else                 state_nxt = S_IDLE;
            end
            S_WRITE:      state_nxt = write_done ? S_IDLE : S_WRITE;
            S_ACK:        state_nxt = S_IDLE;
            S_REPLAY_REQ: state_nxt = (replay_num_q == RN_LAST) ? S_RETRAIN : S_WAIT_BUSY;
            S_RETRAIN:    state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!busy_n)                state_nxt = S_WAIT_BUSY;
                else if (num_to_rep != '0)  state_nxt = S_REPLAY_RD;
                else                        state_nxt = S_IDLE;
            end
            S_REPLAY_RD:  state_nxt = replay_done ? S_IDLE : S_REPLAY_RD;
            default:      state_nxt = S_RESET;
        endcase
    end

    // Counters and latches
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            count_to     <= '0;
            replay_num_q <= '0;
            to_lat       <= 1'b0;
            ak_lat       <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    count_q <= '0;
                    // Capture the replay cause on entry so REPLAY_REQ can
                    // present it from a register in its own cycle.
                    if (state_nxt == S_REPLAY_REQ) begin
                        to_lat <= to_i;
                        ak_lat <= (acknak_i == 2'b10) ? 2'b10 : 2'b00;
                    end
                end
                S_WRITE:      count_q <= write_done ? '0 : count_q + CNT_W'(1);
                S_ACK:        replay_num_q <= '0;
                S_REPLAY_REQ: begin
                    if (replay_num_q != RN_LAST) begin
                        replay_num_q <= replay_num_q + RN_W'(1);
                    end
                end
                S_RETRAIN:    replay_num_q <= '0;
                S_WAIT_BUSY: begin
                    count_to <= num_to_rep;
                    count_q  <= '0;
                end
                S_REPLAY_RD:  count_q <= replay_done ? '0 : count_q + CNT_W'(1);
                default:      count_q <= '0;
            endcase
        end
    end

    // Output decode
    always_comb begin
        rst_o     = 1'b0;
        we_o      = 1'b0;
        to_o      = 1'b0;
        acknak_o  = 2'b00;
        rdy_o     = 1'b0;
        busy_n_o  = 1'b0;
        rep_o     = 1'b0;
        seg_sel   = '0;
        retrain_o = 1'b0;
        case (state)
            S_RESET: begin
                rst_o    = 1'b1;
                busy_n_o = 1'b1;
            end
            S_IDLE: begin
                busy_n_o = 1'b1;
                rdy_o    = rdy_i;
            end
            S_WRITE: begin
                we_o     = 1'b1;
                busy_n_o = 1'b1;
                seg_sel  = count_q[SEL_W-1:0];
            end
            S_ACK: begin
                acknak_o = 2'b01;
                busy_n_o = 1'b1;
            end
            S_REPLAY_REQ, S_WAIT_BUSY: begin
                to_o     = to_lat;
                acknak_o = ak_lat;
            end
            S_RETRAIN: begin
                to_o      = to_lat;
                acknak_o  = ak_lat;
                retrain_o = 1'b1;
            end
            S_REPLAY_RD: rep_o = 1'b1;
            default: begin
                rst_o    = 1'b1;
                busy_n_o = 1'b1;
            end
        endcase
    end

    assign count      = count_q;
    assign replay_num = replay_num_q;

endmodule

// File: tb/tb_replay_ctrl_p.sv
module tb_replay_ctrl_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_i;
    logic [1:0]  acknak_i;
    logic        to_i;
    logic        busy_n;
    logic        rdy_i;
    logic [11:0] num_to_rep;
    logic        rst_o;
    logic        we_o;
    logic        to_o;
    logic [1:0]  acknak_o;
    logic        rdy_o;
    logic        busy_n_o;
    logic        rep_o;
    logic [3:0]  seg_sel;
    logic [11:0] count;
    logic [1:0]  replay_num;
    logic        retrain_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    replay_ctrl_p #(
        .SEGS_PER_TLP(10), .CNT_W(12), .SEL_W(4), .REPLAY_LIMIT(4), .RN_W(2)
    ) dut (
        .clk(clk), .reset(reset), .we_i(we_i), .acknak_i(acknak_i), .to_i(to_i),
        .busy_n(busy_n), .rdy_i(rdy_i), .num_to_rep(num_to_rep),
        .rst_o(rst_o), .we_o(we_o), .to_o(to_o), .acknak_o(acknak_o),
        .rdy_o(rdy_o), .busy_n_o(busy_n_o), .rep_o(rep_o), .seg_sel(seg_sel),
        .count(count), .replay_num(replay_num), .retrain_o(retrain_o)
    );

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({rst_o, busy_n_o, we_o, rep_o, to_o, acknak_o, rdy_o, retrain_o} !== 9'b110000000
                || count !== 12'd0 || seg_sel !== 4'd0 || replay_num !== 2'd0) begin
                $display("FAIL reset_hold cyc%0d: rst=%b busy_n=%b we=%b rep=%b to=%b ak=%b rdy=%b rt=%b cnt=%0d sel=%0d rn=%0d, expected rst=1 busy_n=1 others 0",
                         i, rst_o, busy_n_o, we_o, rep_o, to_o, acknak_o, rdy_o, retrain_o, count, seg_sel, replay_num);
                n_fail++;
            end
        end
        reset = 1'b0;
        n_tests++;
        if (rst_o !== 1'b1 || busy_n_o !== 1'b1 || rdy_o !== 1'b0) begin
            $display("FAIL reset_tail: rst=%b busy_n=%b rdy=%b, expected 1 1 0", rst_o, busy_n_o, rdy_o);
            n_fail++;
        end
        step();
        n_tests++;
        if (rst_o !== 1'b0 || busy_n_o !== 1'b1 || rdy_o !== 1'b1) begin
            $display("FAIL idle_entry: rst=%b busy_n=%b rdy=%b, expected 0 1 1", rst_o, busy_n_o, rdy_o);
            n_fail++;
        end
        rdy_i = 1'b0;
        #1;
        n_tests++;
        if (rdy_o !== 1'b0) begin
            $display("FAIL idle_rdy_track: rdy_o=%b, expected 0", rdy_o);
            n_fail++;
        end
        rdy_i = 1'b1;
    endtask

    task automatic test_write();
        we_i = 1'b1;
        step();
        we_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (we_o !== 1'b1 || seg_sel !== 4'(i) || count !== 12'(i) || rdy_o !== 1'b0 || busy_n_o !== 1'b1) begin
                $display("FAIL write_seg%0d: we=%b sel=%0d cnt=%0d rdy=%b busy_n=%b, expected 1 %0d %0d 0 1",
                         i, we_o, seg_sel, count, rdy_o, busy_n_o, i, i);
                n_fail++;
            end
            step();
        end
        n_tests++;
        if (we_o !== 1'b0 || count !== 12'd0 || seg_sel !== 4'd0 || rdy_o !== 1'b1) begin
            $display("FAIL write_end: we=%b cnt=%0d sel=%0d rdy=%b, expected 0 0 0 1", we_o, count, seg_sel, rdy_o);
            n_fail++;
        end
    endtask

    task automatic test_nak_replay();
        acknak_i   = 2'b10;
        num_to_rep = 12'd5;
        busy_n     = 1'b0;
        step();
        n_tests++;
        if (acknak_o !== 2'b10 || to_o !== 1'b0 || busy_n_o !== 1'b0 || replay_num !== 2'd0) begin
            $display("FAIL nak_req: ak=%b to=%b busy_n=%b rn=%0d, expected 10 0 0 0", acknak_o, to_o, busy_n_o, replay_num);
            n_fail++;
        end
        step();
        acknak_i = 2'b00;
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (acknak_o !== 2'b10 || busy_n_o !== 1'b0 || rep_o !== 1'b0 || replay_num !== 2'd1) begin
                $display("FAIL nak_wait%0d: ak=%b busy_n=%b rep=%b rn=%0d, expected 10 0 0 1", j, acknak_o, busy_n_o, rep_o, replay_num);
                n_fail++;
            end
            if (j == 3) busy_n = 1'b1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (rep_o !== 1'b1 || count !== 12'(i) || acknak_o !== 2'b00 || busy_n_o !== 1'b0) begin
                $display("FAIL nak_rd%0d: rep=%b cnt=%0d ak=%b busy_n=%b, expected 1 %0d 00 0", i, rep_o, count, acknak_o, busy_n_o, i);
                n_fail++;
            end
            busy_n = (i != 2);
            step();
        end
        n_tests++;
        if (rep_o !== 1'b0 || busy_n_o !== 1'b1 || count !== 12'd0) begin
            $display("FAIL nak_end: rep=%b busy_n=%b cnt=%0d, expected 0 1 0", rep_o, busy_n_o, count);
            n_fail++;
        end
    endtask

    task automatic test_write_then_ack();
        we_i     = 1'b1;
        acknak_i = 2'b01;
        step();
        we_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (we_o !== 1'b1 || seg_sel !== 4'(i) || acknak_o !== 2'b00) begin
                $display("FAIL wa_seg%0d: we=%b sel=%0d ak=%b, expected 1 %0d 00", i, we_o, seg_sel, acknak_o, i);
                n_fail++;
            end
            step();
        end
        n_tests++;
        if (we_o !== 1'b0 || acknak_o !== 2'b00 || busy_n_o !== 1'b1) begin
            $display("FAIL wa_idle: we=%b ak=%b busy_n=%b, expected 0 00 1", we_o, acknak_o, busy_n_o);
            n_fail++;
        end
        step();
        acknak_i = 2'b00;
        n_tests++;
        if (acknak_o !== 2'b01 || busy_n_o !== 1'b1 || we_o !== 1'b0) begin
            $display("FAIL wa_ack: ak=%b busy_n=%b we=%b, expected 01 1 0", acknak_o, busy_n_o, we_o);
            n_fail++;
        end
        step();
        n_tests++;
        if (acknak_o !== 2'b00 || replay_num !== 2'd0) begin
            $display("FAIL wa_after: ak=%b rn=%0d, expected 00 0", acknak_o, replay_num);
            n_fail++;
        end
    endtask

    task automatic test_timeout_retrain();
        num_to_rep = 12'd2;
        busy_n     = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            to_i = 1'b1;
            step();
            n_tests++;
            if (to_o !== 1'b1 || acknak_o !== 2'b00 || busy_n_o !== 1'b0 || retrain_o !== 1'b0) begin
                $display("FAIL to_req%0d: to=%b ak=%b busy_n=%b rt=%b, expected 1 00 0 0", k, to_o, acknak_o, busy_n_o, retrain_o);
                n_fail++;
            end
            step();
            to_i = 1'b0;
            if (k == 4) begin
                n_tests++;
                if (retrain_o !== 1'b1 || to_o !== 1'b1 || busy_n_o !== 1'b0) begin
                    $display("FAIL to_retrain: rt=%b to=%b busy_n=%b, expected 1 1 0", retrain_o, to_o, busy_n_o);
                    n_fail++;
                end
                step();
            end
            n_tests++;
            if (replay_num !== 2'(k % 4) || retrain_o !== 1'b0 || to_o !== 1'b1 || rep_o !== 1'b0) begin
                $display("FAIL to_wait%0d: rn=%0d rt=%b to=%b rep=%b, expected %0d 0 1 0", k, replay_num, retrain_o, to_o, rep_o, k % 4);
                n_fail++;
            end
            step();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (rep_o !== 1'b1 || count !== 12'(i) || retrain_o !== 1'b0) begin
                    $display("FAIL to_rd%0d_%0d: rep=%b cnt=%0d rt=%b, expected 1 %0d 0", k, i, rep_o, count, retrain_o, i);
                    n_fail++;
                end
                step();
            end
            n_tests++;
            if (rep_o !== 1'b0 || busy_n_o !== 1'b1) begin
                $display("FAIL to_end%0d: rep=%b busy_n=%b, expected 0 1", k, rep_o, busy_n_o);
                n_fail++;
            end
        end
    endtask

    task automatic test_zero_replay();
        acknak_i   = 2'b10;
        num_to_rep = 12'd0;
        busy_n     = 1'b1;
        step();
        step();
        acknak_i = 2'b00;
        n_tests++;
        if (busy_n_o !== 1'b0 || rep_o !== 1'b0 || replay_num !== 2'd1) begin
            $display("FAIL zero_wait: busy_n=%b rep=%b rn=%0d, expected 0 0 1", busy_n_o, rep_o, replay_num);
            n_fail++;
        end
        step();
        n_tests++;
        if (rep_o !== 1'b0 || busy_n_o !== 1'b1 || rdy_o !== 1'b1) begin
            $display("FAIL zero_idle: rep=%b busy_n=%b rdy=%b, expected 0 1 1", rep_o, busy_n_o, rdy_o);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_replay();
        num_to_rep = 12'd6;
        to_i       = 1'b1;
        step();
        step();
        to_i = 1'b0;
        step();
        step();
        n_tests++;
        if (rep_o !== 1'b1 || count !== 12'd1 || replay_num !== 2'd2) begin
            $display("FAIL mid_rd: rep=%b cnt=%0d rn=%0d, expected 1 1 2", rep_o, count, replay_num);
            n_fail++;
        end
        reset = 1'b1;
        step();
        n_tests++;
        if (rep_o !== 1'b0 || rst_o !== 1'b1 || count !== 12'd0 || replay_num !== 2'd0 || busy_n_o !== 1'b1) begin
            $display("FAIL mid_reset: rep=%b rst=%b cnt=%0d rn=%0d busy_n=%b, expected 0 1 0 0 1", rep_o, rst_o, count, replay_num, busy_n_o);
            n_fail++;
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (rst_o !== 1'b0 || rep_o !== 1'b0 || busy_n_o !== 1'b1) begin
            $display("FAIL mid_recover: rst=%b rep=%b busy_n=%b, expected 0 0 1", rst_o, rep_o, busy_n_o);
            n_fail++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        we_i       = 1'b0;
        acknak_i   = 2'b00;
        to_i       = 1'b0;
        busy_n     = 1'b1;
        rdy_i      = 1'b1;
        num_to_rep = 12'd0;
        test_reset();
        test_write();
        test_nak_replay();
        test_write_then_ack();
        test_timeout_retrain();
        test_zero_replay();
        test_reset_mid_replay();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
